// File: rtl/sdram_stream_reader_if.sv
// Toggle-handshake SDRAM port: a request is outstanding while req != ack.
// The reader drives the device side and the memory controller drives the memory side.
interface sdram_bus #(
   parameter int ADDR_BITS = 20
);
   logic                 req;
   logic                 ack;
   logic                 we;
   logic                 refresh;
   logic [ADDR_BITS-1:0] address;
   logic [15:0]          data_write;
   logic [15:0]          data_read;

   modport device (output req, we, address, data_write, refresh, input ack, data_read);
   modport memory (input req, we, address, data_write, refresh, output ack, data_read);
endinterface

// File: rtl/sdram_stream_reader.sv
// Streams a block of SDRAM words into an output FIFO over a toggle handshake.
// Optional auto-refresh insertion is compiled in with SDRAM_READER_REFRESH_EN.
module sdram_stream_reader #(
   parameter int ADDR_BITS        = 20,
   parameter int FIFO_DEPTH       = 8,
   parameter int REFRESH_INTERVAL = 780
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [ADDR_BITS-1:0] start_addr,
   input  logic [ADDR_BITS-1:0] length,
   output logic                 busy,
   output logic                 done,
   output logic [15:0]          out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   sdram_bus.device             ram,
   output logic [1:0]           debug_state
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      IDLE, ISSUE, WAIT
`ifdef SDRAM_READER_REFRESH_EN
      , REFRESH_WAIT
`endif
   } state_t;

   state_t               state, state_next;
   logic [ADDR_BITS-1:0] cur_addr, remaining, issue_addr, address_q;
   logic [15:0]          fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        count;
   logic                 req_q, bus_idle, full, push, pop;
   logic                 start_ok, load, issue, advance, done_next, take_refresh;

   // Bus: the reader owns req and inverts it to issue; the request completes in the
   // cycle ack equals req, with data_read valid then. Output: pop when out_valid & out_ready.
   assign bus_idle       = (ram.ack == req_q);
   assign ram.req        = req_q;
   assign ram.address    = address_q;
   assign ram.we         = 1'b0;
   assign ram.data_write = 16'h0000;

   assign full        = (count == CW'(FIFO_DEPTH));
   assign out_valid   = (count != '0);
   assign out_data    = fifo_mem[rd_ptr];
   assign pop         = out_valid && out_ready;
   assign start_ok    = start && !busy;
   assign debug_state = state;

`ifdef SDRAM_READER_REFRESH_EN
   localparam int RW = $clog2(REFRESH_INTERVAL + 1);
   logic [RW-1:0] refresh_cnt;
   logic          refresh_pending, refresh_q;
   state_t        resume, resume_next;
`endif

   always_comb begin
      state_next = state;
      issue      = 1'b0;
      issue_addr = cur_addr;
      load       = 1'b0;
      push       = 1'b0;
      advance    = 1'b0;
      done_next  = 1'b0;
`ifdef SDRAM_READER_REFRESH_EN
      take_refresh = 1'b0;
      resume_next  = resume;
`endif
      if (start_ok) begin
         if (length == '0) done_next = 1'b1;
         else              load      = 1'b1;
      end
      case (state)
         IDLE: begin
            if (load) begin
               if (!full && bus_idle) begin
                  issue      = 1'b1;
                  issue_addr = start_addr;
                  state_next = WAIT;
               end else begin
                  state_next = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (!full && bus_idle) begin
               issue      = 1'b1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (bus_idle) begin
               push    = 1'b1;
               advance = 1'b1;
               if (remaining == ADDR_BITS'(1)) begin
                  done_next  = 1'b1;
                  state_next = IDLE;
               end else begin
                  state_next = ISSUE;
               end
            end
         end
`ifdef SDRAM_READER_REFRESH_EN
         REFRESH_WAIT: begin
            if (load) resume_next = ISSUE;
            if (bus_idle) state_next = resume_next;
         end
`endif
         default: state_next = IDLE;
      endcase
`ifdef SDRAM_READER_REFRESH_EN
      // A completing read in WAIT is handled first; refresh then wins the next free slot.
      if (refresh_pending && bus_idle && (state == IDLE || state == ISSUE)) begin
         take_refresh = 1'b1;
         issue        = 1'b0;
         resume_next  = (state_next == WAIT) ? ISSUE : state_next;
         state_next   = REFRESH_WAIT;
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         req_q     <= 1'b0;
         address_q <= '0;
         cur_addr  <= '0;
         remaining <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state <= state_next;
         done  <= done_next;
         busy  <= (busy & ~done) | start_ok;
         if (load) begin
            cur_addr  <= start_addr;
            remaining <= length;
         end
         if (issue || take_refresh) req_q <= ~req_q;
         if (issue) address_q <= issue_addr;
         if (advance) begin
            cur_addr  <= cur_addr + ADDR_BITS'(1);
            remaining <= remaining - ADDR_BITS'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= ram.data_read;
   end

`ifdef SDRAM_READER_REFRESH_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         refresh_cnt     <= '0;
         refresh_pending <= 1'b0;
         refresh_q       <= 1'b0;
         resume          <= IDLE;
      end else begin
         if (refresh_cnt == RW'(REFRESH_INTERVAL - 1)) refresh_cnt <= '0;
         else                                          refresh_cnt <= refresh_cnt + RW'(1);
         refresh_pending <= (refresh_cnt == RW'(REFRESH_INTERVAL - 1)) |
                            (refresh_pending & ~take_refresh);
         if (take_refresh)                          refresh_q <= 1'b1;
         else if (state == REFRESH_WAIT && bus_idle) refresh_q <= 1'b0;
         resume <= resume_next;
      end
   end
   assign ram.refresh = refresh_q;
`else
   logic unused_cfg;
   assign take_refresh = 1'b0;
   assign ram.refresh  = 1'b0;
   assign unused_cfg   = (REFRESH_INTERVAL == 0);
`endif
endmodule

// File: tb/tb_sdram_stream_reader.sv
// Bench for sdram_stream_reader: toggle-handshake memory model, word scoreboard,
// and per-scenario tasks. Define SDRAM_READER_REFRESH_EN to also exercise refresh.
module tb_sdram_stream_reader;
   localparam int AW    = 20;
   localparam int DEPTH = 8;
   localparam int RI    = 16;

   logic          clk = 1'b0;
   logic          reset, start, out_ready;
   logic [AW-1:0] start_addr, length;
   logic          busy, done, out_valid;
   logic [15:0]   out_data;
   logic [1:0]    debug_state;

   sdram_bus #(.ADDR_BITS(AW)) ram ();

   sdram_stream_reader #(.ADDR_BITS(AW), .FIFO_DEPTH(DEPTH), .REFRESH_INTERVAL(RI)) dut (
      .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .length(length),
      .busy(busy), .done(done), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .ram(ram), .debug_state(debug_state)
   );

   always #5 clk = ~clk;

   int            checks = 0, failures = 0;
   int            reads = 0, refreshes = 0, words = 0, done_count = 0;
   int            lat_min = 1, lat_max = 4;
   logic [15:0]   exp_q[$];
   logic [AW-1:0] exp_addr_q[$];

   function automatic logic [15:0] data_of(input logic [AW-1:0] a);
      return {a[3:0], a[15:4]} ^ 16'h3C5A ^ {12'h000, a[19:16]};
   endfunction

   // Memory model: serves any req != ack after a random latency by toggling ack.
   logic          ack_r = 1'b0, req_prev = 1'b0, m_active = 1'b0, m_ref = 1'b0, m_req = 1'b0;
   logic [15:0]   rd_r = 16'h0000;
   logic [AW-1:0] m_addr = '0, want_addr;
   int            m_cnt = 0;
   time           last_ref = 0;
   assign ram.ack       = ack_r;
   assign ram.data_read = rd_r;

   always @(posedge clk) begin
      if (reset) begin
         req_prev <= ram.req;
         last_ref <= 0;
      end else if (ram.req != req_prev) begin
         req_prev <= ram.req;
         checks++;
         if (ack_r !== req_prev) begin
            failures++;
            $display("FAIL one_outstanding: ack=%0b before issue, required %0b", ack_r, req_prev);
         end
         checks++;
         if (ram.we !== 1'b0 || ram.data_write !== 16'h0000) begin
            failures++;
            $display("FAIL write_lines: we=%0b data_write=%h, required 0 and 0000", ram.we, ram.data_write);
         end
         if (ram.refresh === 1'b1) begin
            refreshes++;
            if (last_ref != 0) begin
               checks++;
               if ($time - last_ref > (RI + lat_max + 6) * 10) begin
                  failures++;
                  $display("FAIL refresh_gap: %0t between refreshes, required <= %0d", $time - last_ref, (RI + lat_max + 6) * 10);
               end
            end
            last_ref <= $time;
         end else begin
            reads++;
            checks++;
            if (exp_addr_q.size() == 0) begin
               failures++;
               $display("FAIL read_addr: unexpected request at %h, required none", ram.address);
            end else begin
               want_addr = exp_addr_q.pop_front();
               if (ram.address !== want_addr) begin
                  failures++;
                  $display("FAIL read_addr: got %h, required %h", ram.address, want_addr);
               end
            end
         end
      end
      if (!reset && m_active && ram.req == m_req && ram.req != ack_r) begin
         checks++;
         if (ram.address !== m_addr || ram.refresh !== m_ref) begin
            failures++;
            $display("FAIL hold: addr=%h refresh=%0b, required %h %0b", ram.address, ram.refresh, m_addr, m_ref);
         end
      end
      if (!m_active) begin
         if (ram.req != ack_r) begin
            m_active <= 1'b1;
            m_cnt    <= $urandom_range(lat_max, lat_min);
            m_addr   <= ram.address;
            m_ref    <= ram.refresh;
            m_req    <= ram.req;
         end
      end else if (m_cnt <= 1) begin
         ack_r    <= ~ack_r;
         rd_r     <= data_of(m_addr);
         m_active <= 1'b0;
      end else begin
         m_cnt <= m_cnt - 1;
      end
   end

   logic [15:0] mon_exp;
   always @(negedge clk) begin
      if (!reset) begin
         if (done) done_count++;
         if (out_valid && out_ready) begin
            words++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL out_data: unexpected word %h, required none", out_data);
            end else begin
               mon_exp = exp_q.pop_front();
               if (out_data !== mon_exp) begin
                  failures++;
                  $display("FAIL out_data: got %h, required %h", out_data, mon_exp);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [AW-1:0] a, input logic [AW-1:0] l);
      logic [AW-1:0] ai;
      for (int i = 0; i < int'(l); i++) begin
         ai = a + AW'(i);
         exp_q.push_back(data_of(ai));
         exp_addr_q.push_back(ai);
      end
      start_addr = a;
      length     = l;
      start      = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input bit rand_ready);
      int n = 0;
      while ((busy || exp_q.size() != 0 || ram.req != ram.ack) && n < budget) begin
         if (rand_ready) out_ready = 1'($urandom_range(1, 0));
         tick();
         n++;
      end
      out_ready = 1'b1;
      checks++;
      if (n >= budget) begin
         failures++;
         $display("FAIL idle_timeout: still busy after %0d cycles, required idle", n);
      end
   endtask

   task automatic wait_bus_idle();
      int n = 0;
      while (ram.req != ram.ack && n < 50) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; out_ready = 1'b0; start_addr = '0; length = '0;
      tick();
      tick();
      checks += 7;
      if (ram.req !== 1'b0)     begin failures++; $display("FAIL reset_req: got %0b, required 0", ram.req); end
      if (ram.refresh !== 1'b0) begin failures++; $display("FAIL reset_refresh: got %0b, required 0", ram.refresh); end
      if (ram.address !== '0)   begin failures++; $display("FAIL reset_addr: got %h, required 0", ram.address); end
      if (busy !== 1'b0)        begin failures++; $display("FAIL reset_busy: got %0b, required 0", busy); end
      if (done !== 1'b0)        begin failures++; $display("FAIL reset_done: got %0b, required 0", done); end
      if (out_valid !== 1'b0)   begin failures++; $display("FAIL reset_valid: got %0b, required 0", out_valid); end
      if (debug_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d, required 0", debug_state); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int w0 = words, d0 = done_count, r0 = reads;
      logic rq;
      lat_min = 3; lat_max = 3; out_ready = 1'b1;
      wait_bus_idle();
      rq = ram.req;
      pulse_start(20'h00100, 20'd4);
      checks += 2;
      if (ram.req === rq) begin failures++; $display("FAIL issue_latency: req=%0b, required toggled from %0b", ram.req, rq); end
      if (busy !== 1'b1)  begin failures++; $display("FAIL basic_busy: got %0b, required 1", busy); end
      wait_idle(300, 1'b0);
      tick();
      checks += 4;
      if (words - w0 != 4)      begin failures++; $display("FAIL basic_words: got %0d, required 4", words - w0); end
      if (done_count - d0 != 1) begin failures++; $display("FAIL basic_done: got %0d pulses, required 1", done_count - d0); end
      if (reads - r0 != 4)      begin failures++; $display("FAIL basic_reads: got %0d, required 4", reads - r0); end
      if (busy !== 1'b0)        begin failures++; $display("FAIL basic_busy_end: got %0b, required 0", busy); end
   endtask

   task automatic test_zero_length();
      int d0 = done_count, r0 = reads;
      pulse_start(20'h00777, 20'd0);
      checks += 2;
      if (done !== 1'b1) begin failures++; $display("FAIL zero_done: got %0b, required 1", done); end
      if (busy !== 1'b1) begin failures++; $display("FAIL zero_busy: got %0b, required 1", busy); end
      repeat (10) tick();
      checks += 3;
      if (reads != r0)          begin failures++; $display("FAIL zero_reads: got %0d, required %0d", reads, r0); end
      if (done_count - d0 != 1) begin failures++; $display("FAIL zero_pulses: got %0d, required 1", done_count - d0); end
      if (busy !== 1'b0)        begin failures++; $display("FAIL zero_busy_end: got %0b, required 0", busy); end
   endtask

   task automatic test_backpressure();
      int w0 = words, r0 = reads;
      lat_min = 1; lat_max = 4; out_ready = 1'b0;
      pulse_start(20'h03000, 20'd12);
      repeat (80) tick();
      checks += 3;
      if (reads - r0 != DEPTH) begin failures++; $display("FAIL stall_reads: got %0d, required %0d", reads - r0, DEPTH); end
      if (out_valid !== 1'b1)  begin failures++; $display("FAIL stall_valid: got %0b, required 1", out_valid); end
      if (busy !== 1'b1)       begin failures++; $display("FAIL stall_busy: got %0b, required 1", busy); end
`ifndef SDRAM_READER_REFRESH_EN
      checks++;
      if (debug_state !== 2'd1) begin failures++; $display("FAIL stall_state: got %0d, required 1", debug_state); end
`endif
      out_ready = 1'b1;
      wait_idle(400, 1'b0);
      checks += 2;
      if (reads - r0 != 12) begin failures++; $display("FAIL resume_reads: got %0d, required 12", reads - r0); end
      if (words - w0 != 12) begin failures++; $display("FAIL resume_words: got %0d, required 12", words - w0); end
   endtask

   task automatic test_wrap();
      int w0 = words, r0 = reads;
      pulse_start(20'hFFFFE, 20'd4);
      wait_idle(300, 1'b1);
      checks += 2;
      if (reads - r0 != 4) begin failures++; $display("FAIL wrap_reads: got %0d, required 4", reads - r0); end
      if (words - w0 != 4) begin failures++; $display("FAIL wrap_words: got %0d, required 4", words - w0); end
   endtask

   task automatic test_reset_stale();
      int n = 0, w0, r0;
      lat_min = 4; lat_max = 4; out_ready = 1'b1;
      wait_bus_idle();
      pulse_start(20'h00500, 20'd6);
      tick();
      reset = 1'b1;
      #1;
      checks += 3;
      if (ram.req !== 1'b0)   begin failures++; $display("FAIL abort_req: got %0b, required 0", ram.req); end
      if (busy !== 1'b0)      begin failures++; $display("FAIL abort_busy: got %0b, required 0", busy); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_valid: got %0b, required 0", out_valid); end
      tick();
      reset = 1'b0;
      exp_q.delete();
      exp_addr_q.delete();
      w0 = words; r0 = reads;
      while (ram.ack == ram.req && n < 20) begin tick(); n++; end
      checks++;
      if (n >= 20) begin failures++; $display("FAIL stale_ack: no stale ack within %0d cycles, required one", n); end
      pulse_start(20'h00A00, 20'd3);
      n = 0;
      while (ram.ack != 1'b0 && n < 20) begin
         checks++;
         if (ram.req !== 1'b0) begin failures++; $display("FAIL stale_hold: req=%0b while ack=%0b, required 0", ram.req, ram.ack); end
         tick();
         n++;
      end
      wait_idle(300, 1'b0);
      checks += 2;
      if (reads - r0 != 3) begin failures++; $display("FAIL stale_reads: got %0d, required 3", reads - r0); end
      if (words - w0 != 3) begin failures++; $display("FAIL stale_words: got %0d, required 3", words - w0); end
   endtask

   task automatic test_random();
      int w0 = words, total = 0;
      lat_min = 1; lat_max = 4;
      for (int k = 0; k < 6; k++) begin
         int l = $urandom_range(20, 1);
         total += l;
         pulse_start(AW'($urandom_range(32'hFFFFF, 0)), AW'(l));
         wait_idle(800, 1'b1);
      end
      checks++;
      if (words - w0 != total) begin failures++; $display("FAIL random_words: got %0d, required %0d", words - w0, total); end
   endtask

`ifdef SDRAM_READER_REFRESH_EN
   task automatic test_refresh();
      int w0 = words, f0 = refreshes;
      lat_min = 1; lat_max = 3; out_ready = 1'b1;
      pulse_start(20'h04000, 20'd64);
      wait_idle(2000, 1'b0);
      checks += 2;
      if (words - w0 != 64)     begin failures++; $display("FAIL refresh_words: got %0d, required 64", words - w0); end
      if (refreshes - f0 < 8)   begin failures++; $display("FAIL refresh_count: got %0d, required >= 8", refreshes - f0); end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time %0t, required completion earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_zero_length();
      test_backpressure();
      test_wrap();
      test_reset_stale();
      test_random();
`ifdef SDRAM_READER_REFRESH_EN
      test_refresh();
`endif
      repeat (4) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end
endmodule

// File: doc/sdram_stream_reader.md
SDRAM_STREAM_READER -- requirements
Module: sdram_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 20, meaning SDRAM word-address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning output FIFO entries (power of two, at least 2).
REQ-003 SHALL have parameter REFRESH_INTERVAL, default 780, meaning clk cycles between auto-refresh requests.
REQ-004 SHALL have port clk, input, 1, the single system clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, a one-cycle pulse that launches a transfer.
REQ-007 SHALL have port start_addr, input, ADDR_BITS, the first word address, sampled on start.
REQ-008 SHALL have port length, input, ADDR_BITS, the word count, sampled on start.
REQ-009 SHALL have port busy, output, 1, high while a transfer is active.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse when the last word has entered the FIFO.
REQ-011 SHALL have port out_data, output, 16, the FIFO head word.
REQ-012 SHALL have port out_valid, output, 1, indicating the FIFO is not empty.
REQ-013 SHALL have port out_ready, input, 1, the consumer pop; a pop occurs when out_valid and out_ready are both high.
REQ-014 SHALL have port ram, of type sdram_bus.device, and SHALL drive req, we, address, data_write and refresh while sampling ack and data_read.

Function
REQ-015 SHALL use a toggle handshake: a request is outstanding while ram.req != ram.ack; the block issues a request by inverting req; the request completes on the cycle ram.ack becomes equal to req, with ram.data_read valid in that cycle.
REQ-016 SHALL keep at most one request outstanding and SHALL hold address, we and refresh stable while it is outstanding.
REQ-017 SHALL drive we = 0 and data_write = 0 at all times.
REQ-018 SHALL implement the states IDLE, ISSUE, WAIT and REFRESH_WAIT.
REQ-019 IDLE: SHALL enter ISSUE on start when length != 0; start with length = 0 SHALL pulse done on the next cycle and issue no request.
REQ-020 ISSUE: SHALL toggle req with address = the current address only when the FIFO free count is at least 1, then go to WAIT; otherwise it SHALL stall in ISSUE.
REQ-021 WAIT: on completion SHALL push data_read into the FIFO, increment the address modulo 2^ADDR_BITS, and decrement the remaining count; it SHALL return to ISSUE, or to IDLE with a done pulse when the remaining count reaches 0.
REQ-022 The first req toggle SHALL occur on the cycle after start (1-cycle issue latency) when the FIFO has room.
REQ-023 start SHALL be ignored while busy is high.
REQ-024 The FIFO SHALL accept a simultaneous push and pop when full or empty without data loss; out_data SHALL be the head word, with no bubble between consecutive words.
REQ-025 busy SHALL be high from the cycle after an accepted start until the done cycle, inclusive.

Reset
REQ-026 Asserting reset SHALL immediately set: state IDLE, ram.req 0, ram.refresh 0, ram.address 0, busy 0, done 0, out_valid 0, and FIFO pointers empty.
REQ-027 After reset, the block SHALL issue no request until ram.ack == ram.req, which absorbs a stale acknowledgement from a transfer aborted by reset.

Configuration
REQ-028 With SDRAM_READER_REFRESH_EN defined, a counter SHALL raise refresh_pending every REFRESH_INTERVAL cycles, and at the next point with no request outstanding, in any state, the block SHALL issue a request with refresh = 1 and enter REFRESH_WAIT.
REQ-029 Refresh SHALL take priority over a read, and on completion the block SHALL resume the interrupted state.
REQ-030 Without SDRAM_READER_REFRESH_EN, ram.refresh SHALL be tied to 0 and no counter or REFRESH_WAIT logic SHALL exist.

Verification
REQ-031 start_addr=0x00100, length=4, ack echoing req after 3 cycles, out_ready=1 -> addresses 0x00100..0x00103 in order, 4 words out, done pulse once, busy low afterwards.
REQ-032 length=0 -> done on the next cycle; req never toggles.
REQ-033 length=12, FIFO_DEPTH=8, out_ready=0 -> exactly 8 requests, then a stall; raising out_ready -> the remaining 4 are issued, all 12 words arrive in order.
REQ-034 start_addr=2^ADDR_BITS-2, length=4 -> addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
REQ-035 Reset asserted while a request is outstanding, with the model toggling ack afterwards -> no new req until ack == req; the next start runs a correct transfer.
REQ-036 SDRAM_READER_REFRESH_EN defined, REFRESH_INTERVAL=16, length=64 -> a refresh=1 request about every 16 cycles, never overlapping a read; data is intact.
